// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - frequency-pair request FIFO with dwell/hold pacing for the tone generator
// Optional macro TONE_SCHED_OVERWRITE_EN: a push into a full queue overwrites the tail entry.
module tone_scheduler #(
   parameter int DEPTH_LOG    = 3,
   parameter int DWELL_CYCLES = 65536,
   parameter int HOLD_CYCLES  = 1048576
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   input  logic [4:0]         req_freq1,
   input  logic [4:0]         req_freq2,
   output logic               req_ready,
   input  logic               flush,
   output logic [4:0]         freq_id1,
   output logic [4:0]         freq_id2,
   output logic               new_f,
   output logic               busy,
   output logic [DEPTH_LOG:0] level,
   output logic               overflow
);

   localparam int DEPTH   = 1 << DEPTH_LOG;
   localparam int CNT_MAX = (DWELL_CYCLES > HOLD_CYCLES) ? DWELL_CYCLES : HOLD_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [4:0]         SIL     = 5'b11111;
   localparam logic [DEPTH_LOG:0] DEPTH_V = (DEPTH_LOG + 1)'(DEPTH);
   localparam logic [CW-1:0]      DWELL_LOAD = CW'(DWELL_CYCLES);
   // HOLD is entered one edge after dwell expiry and SILENCE costs one more edge,
   // so the counter is biased to put the silence edge DWELL+HOLD+1 after the pair edge.
   localparam logic [CW-1:0]      HOLD_LOAD  = (HOLD_CYCLES >= 2) ? CW'(HOLD_CYCLES - 2) : '0;

   typedef enum logic [1:0] {IDLE, DWELL, HOLD, SILENCE} state_t;

   state_t               state_q, state_nxt;
   logic [CW-1:0]        cnt_q, cnt_nxt;
   logic [4:0]           f1_nxt, f2_nxt;
   logic                 new_f_nxt;
   logic                 pop;

   logic [9:0]           mem [DEPTH];
   logic [DEPTH_LOG-1:0] wptr, rptr, tail;
   logic                 full, empty, push_req, push, drop, ovw;
   logic [9:0]           head;
   logic [4:0]           n1, n2;

   assign full     = (level == DEPTH_V);
   assign empty    = (level == '0);
   assign push_req = req_valid && !flush;
   assign tail     = wptr - DEPTH_LOG'(1);
   assign head     = mem[rptr];
   assign busy     = (state_q != IDLE);

`ifdef TONE_SCHED_OVERWRITE_EN
   assign req_ready = !flush;
   assign push      = push_req && (!full || pop);
   assign ovw       = push_req && full && !pop;
   assign drop      = 1'b0;
`else
   assign req_ready = !full && !flush;
   assign push      = push_req && !full;
   assign ovw       = 1'b0;
   assign drop      = push_req && full;
`endif

   // Normalise the head entry: silent id moves to slot 2, a doubled id collapses to one tone.
   always_comb begin
      n1 = head[9:5];
      n2 = head[4:0];
      if (n1 == SIL && n2 != SIL) begin
         n1 = head[4:0];
         n2 = head[9:5];
      end
      if (n1 == n2 && n1 != SIL) n2 = SIL;
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      f1_nxt    = freq_id1;
      f2_nxt    = freq_id2;
      new_f_nxt = 1'b0;
      pop       = 1'b0;
      if (flush) begin
         state_nxt = SILENCE;
      end else begin
         case (state_q)
            IDLE:    pop = !empty;
            DWELL: begin
               if (cnt_q != '0) begin
                  cnt_nxt = cnt_q - CW'(1);
               end else if (!empty) begin
                  pop = 1'b1;
               end else begin
                  cnt_nxt   = HOLD_LOAD;
                  state_nxt = HOLD;
               end
            end
            HOLD: begin
               if (!empty)              pop       = 1'b1;
               else if (cnt_q != '0)    cnt_nxt   = cnt_q - CW'(1);
               else                     state_nxt = SILENCE;
            end
            SILENCE: begin
               f1_nxt    = SIL;
               f2_nxt    = SIL;
               new_f_nxt = !(freq_id1 == SIL && freq_id2 == SIL);
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
         if (pop) begin
            f1_nxt    = n1;
            f2_nxt    = n2;
            new_f_nxt = ({n1, n2} != {freq_id1, freq_id2});
            cnt_nxt   = DWELL_LOAD;
            state_nxt = DWELL;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         freq_id1 <= SIL;
         freq_id2 <= SIL;
         new_f    <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         freq_id1 <= f1_nxt;
         freq_id2 <= f2_nxt;
         new_f    <= new_f_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= overflow | drop | ovw;
         if (flush) begin
            rptr  <= wptr;
            level <= '0;
         end else begin
            if (push) wptr <= wptr + DEPTH_LOG'(1);
            if (pop)  rptr <= rptr + DEPTH_LOG'(1);
            case ({push, pop})
               2'b10:   level <= level + (DEPTH_LOG + 1)'(1);
               2'b01:   level <= level - (DEPTH_LOG + 1)'(1);
               default: level <= level;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push)     mem[wptr] <= {req_freq1, req_freq2};
      else if (ovw) mem[tail] <= {req_freq1, req_freq2};
   end

endmodule

// File: tb/tb_tone_scheduler.sv
// tb/tb_tone_scheduler.sv - self-checking bench for tone_scheduler against a timeline-based queue model
module tb_tone_scheduler;

   localparam int DL    = 3;
   localparam int DW    = 16;
   localparam int HD    = 32;
   localparam int DEPTH = 8;
   localparam logic [9:0] SIL2 = 10'h3ff;
   localparam int M_IDLE = 0, M_ACT = 1, M_SIL = 2;

   logic       clock = 1'b0;
   logic       reset, req_valid, flush, req_ready, new_f, busy, overflow;
   logic [4:0] req_freq1, req_freq2, freq_id1, freq_id2;
   logic [DL:0] level;

   int total = 0;
   int bad   = 0;

   logic [9:0] mq[$];
   logic [9:0] m_pres;
   int         m_mode, m_last, t;
   logic       m_newf, m_ovf;

   always #5 clock = ~clock;

   tone_scheduler #(.DEPTH_LOG(DL), .DWELL_CYCLES(DW), .HOLD_CYCLES(HD)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_freq1(req_freq1),
      .req_freq2(req_freq2), .req_ready(req_ready), .flush(flush), .freq_id1(freq_id1),
      .freq_id2(freq_id2), .new_f(new_f), .busy(busy), .level(level), .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] norm(input logic [9:0] p);
      logic [4:0] a, b;
      a = p[9:5];
      b = p[4:0];
      if (a == 5'd31 && b != 5'd31) begin
         a = p[4:0];
         b = p[9:5];
      end
      if (a == b && a != 5'd31) b = 5'd31;
      return {a, b};
   endfunction

   function automatic logic [4:0] rf();
      if ($urandom_range(0, 3) == 0) return 5'd31;
      return 5'($urandom_range(0, 6));
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pres = SIL2;
      m_mode = M_IDLE;
      m_last = 0;
      m_newf = 1'b0;
      m_ovf  = 1'b0;
      t      = 0;
   endtask

   // One clock edge of the reference: pops allowed once DW edges have passed since the
   // last pop, silence follows DW+HD edges after the last pop if nothing arrived.
   task automatic model_edge(input logic v, input logic [4:0] a, input logic [4:0] b, input logic fl);
      int         n0;
      logic       pop_ok;
      logic [9:0] p;
      n0 = mq.size();
      t++;
      m_newf = 1'b0;
      if (fl) begin
         mq.delete();
         m_mode = M_SIL;
      end else begin
         pop_ok = (n0 > 0) && (m_mode == M_IDLE || (m_mode == M_ACT && t >= m_last + DW + 1));
         if (m_mode == M_SIL) begin
            m_newf = (m_pres != SIL2);
            m_pres = SIL2;
            m_mode = M_IDLE;
         end else if (pop_ok) begin
            p      = norm(mq.pop_front());
            m_newf = (p != m_pres);
            m_pres = p;
            m_last = t;
            m_mode = M_ACT;
         end else if (m_mode == M_ACT && t >= m_last + DW + HD) begin
            m_mode = M_SIL;
         end
         if (v) begin
            if (n0 < DEPTH) mq.push_back({a, b});
`ifdef TONE_SCHED_OVERWRITE_EN
            else if (pop_ok) mq.push_back({a, b});
            else begin
               mq[mq.size() - 1] = {a, b};
               m_ovf = 1'b1;
            end
`else
            else m_ovf = 1'b1;
`endif
         end
      end
   endtask

   task automatic cyc(input logic v, input logic [4:0] a, input logic [4:0] b, input logic fl);
      logic exp_rdy;
      req_valid = v;
      req_freq1 = a;
      req_freq2 = b;
      flush     = fl;
      #1;
`ifdef TONE_SCHED_OVERWRITE_EN
      exp_rdy = !fl;
`else
      exp_rdy = !fl && (mq.size() != DEPTH);
`endif
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clock);
      model_edge(v, a, b, fl);
      #1;
      chk("new_f",    32'(new_f),    32'(m_newf));
      chk("freq_id1", 32'(freq_id1), 32'(m_pres[9:5]));
      chk("freq_id2", 32'(freq_id2), 32'(m_pres[4:0]));
      chk("level",    32'(level),    32'(mq.size()));
      chk("busy",     32'(busy),     32'(m_mode != M_IDLE));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic wait_newf(input int maxc, output int n);
      n = 0;
      do begin
         cyc(1'b0, 5'd0, 5'd0, 1'b0);
         n++;
      end while (new_f !== 1'b1 && n < maxc);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_f1"},    32'(freq_id1), 32'd31);
      chk({tag, "_f2"},    32'(freq_id2), 32'd31);
      chk({tag, "_newf"},  32'(new_f),    32'd0);
      chk({tag, "_busy"},  32'(busy),     32'd0);
      chk({tag, "_level"}, 32'(level),    32'd0);
      chk({tag, "_ovf"},   32'(overflow), 32'd0);
   endtask

   initial begin
      int n;
      int rate;
      reset = 1'b0; req_valid = 1'b0; flush = 1'b0; req_freq1 = '0; req_freq2 = '0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk_reset_vals("rst");
      chk("rst_ready", 32'(req_ready), 32'd1);
      reset = 1'b1;

      // single pair: new_f two edges after the push, silence DW+HD+1 later
      cyc(1'b1, 5'd3, 5'd31, 1'b0);
      cyc(1'b0, 5'd0, 5'd0, 1'b0);
      chk("tp1_newf", 32'(new_f), 32'd1);
      chk("tp1_f1", 32'(freq_id1), 32'd3);
      chk("tp1_f2", 32'(freq_id2), 32'd31);
      chk("tp1_busy", 32'(busy), 32'd1);
      wait_newf(80, n);
      chk("sil_gap", 32'(n), 32'(DW + HD + 1));
      chk("sil_f1", 32'(freq_id1), 32'd31);
      cyc(1'b0, 5'd0, 5'd0, 1'b0);
      chk("sil_idle", 32'(busy), 32'd0);

      // swap and duplicate-id normalisation, back-to-back pacing
      cyc(1'b1, 5'd31, 5'd7, 1'b0);
      cyc(1'b1, 5'd9, 5'd9, 1'b0);
      chk("swap_f1", 32'(freq_id1), 32'd7);
      chk("swap_f2", 32'(freq_id2), 32'd31);
      wait_newf(40, n);
      chk("pace_gap", 32'(n), 32'(DW + 1));
      chk("dup_f1", 32'(freq_id1), 32'd9);
      chk("dup_f2", 32'(freq_id2), 32'd31);
      wait_newf(80, n);
      cyc(1'b0, 5'd0, 5'd0, 1'b0);

      // identical pair twice: one pulse, dwell restarted by the second pop
      cyc(1'b1, 5'd5, 5'd12, 1'b0);
      cyc(1'b1, 5'd5, 5'd12, 1'b0);
      chk("same_newf", 32'(new_f), 32'd1);
      wait_newf(100, n);
      chk("same_gap", 32'(n), 32'(DW + 1 + DW + HD + 1));
      chk("same_sil", 32'(freq_id2), 32'd31);
      cyc(1'b0, 5'd0, 5'd0, 1'b0);

      // fill during dwell, then one more push
      cyc(1'b1, 5'd1, 5'd2, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 5'(i + 4), 5'(i + 14), 1'b0);
      chk("full_level", 32'(level), 32'd8);
      req_valid = 1'b1; req_freq1 = 5'd20; req_freq2 = 5'd21;
      #1;
`ifdef TONE_SCHED_OVERWRITE_EN
      chk("full_ready", 32'(req_ready), 32'd1);
`else
      chk("full_ready", 32'(req_ready), 32'd0);
`endif
      cyc(1'b1, 5'd20, 5'd21, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_level", 32'(level), 32'd8);
      cyc(1'b0, 5'd0, 5'd0, 1'b0);

      // asynchronous reset mid-dwell
      reset = 1'b0;
      #2;
      chk_reset_vals("arst");
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_reset();

      // flush at level 4 with a concurrent push
      for (int i = 0; i < 5; i++) cyc(1'b1, 5'(i + 1), 5'(i + 10), 1'b0);
      chk("pre_flush_level", 32'(level), 32'd4);
      cyc(1'b1, 5'd6, 5'd7, 1'b1);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_newf", 32'(new_f), 32'd0);
      cyc(1'b0, 5'd0, 5'd0, 1'b0);
      chk("flush_sil", 32'(new_f), 32'd1);
      chk("flush_f1", 32'(freq_id1), 32'd31);
      chk("flush_ovf", 32'(overflow), 32'd0);
      repeat (4) cyc(1'b0, 5'd0, 5'd0, 1'b0);

      // randomized traffic with varying push rate and occasional flush
      for (int blk = 0; blk < 15; blk++) begin
         rate = $urandom_range(0, 4);
         for (int i = 0; i < 200; i++)
            cyc(($urandom_range(0, 7) < rate), rf(), rf(), ($urandom_range(0, 99) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
